serrcv: RTL
===========

# serrcv

Serial line receiver for the GPU back-channel: samples the asynchronous `rxd` line, deserializes 8N1 frames, and holds each received byte in a one-entry buffer for the internal bus. It is the receive-side counterpart to the existing serial transmit port. It shares the same strobe/write-enable bus style, so the host reads status and data from a two-register window.

## Interface
Parameters:
- BAUD_DIV, 434 — clock cycles per bit; legal range ≥ 4. The count is at full rate and there is no oversampling prescaler.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- stb  in  1  bus strobe; access valid this cycle
- we  in  1  write enable; writes are accepted and ignored
- addr  in  1  0 = status register, 1 = data register
- data_out  out  8  read data, combinational mux of registers; addr 0 → {6'b0, ferr|ovr, rcv_rdy}, addr 1 → rcv_buf
- rxd  in  1  serial input, asynchronous, idle high

## Operation
- Reset (rst=0 at a clock edge):
  - state=IDLE
  - sync flops and rxd_q=1
  - rcv_buf=8'h00, rcv_rdy=0, ovr=0, ferr=0, bit counter=0
  - data_out reads 8'h00 at either address
  - A frame in progress is abandoned; nothing is stored.
- rxd passes through a two-flop synchronizer to give rxd_s. rxd_q is rxd_s delayed by one cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rxd_s=0 and rxd_q=1 (falling edge), load cnt=BAUD_DIV/2−1 (integer division) and go to START. A line held low without a preceding high never starts a frame.
  - START: decrement cnt. At cnt=0, sample rxd_s.
    - If 0: load cnt=BAUD_DIV−1, set bit index 0, go to DATA.
    - If 1: treat as a glitch and return to IDLE.
  - DATA: decrement cnt. At cnt=0, shift rxd_s into shreg MSB (shreg ← {rxd_s, shreg[7:1]}, so LSB is received first), reload cnt=BAUD_DIV−1, and increment the index. After the 8th sample, go to STOP.
  - STOP: decrement cnt. At cnt=0, sample rxd_s, then go to IDLE.
    - If 1: deliver shreg.
    - If 0: set ferr and discard shreg.
- Delivery (on the edge following the stop sample):
  - If rcv_rdy=0, or a data read occurs in the same cycle: rcv_buf←shreg, rcv_rdy←1.
  - Otherwise: keep the old rcv_buf, drop the new byte, set ovr.
- Bus side:
  - Data read (stb=1, we=0, addr=1) clears rcv_rdy at that edge, unless a delivery occurs in the same cycle, in which case rcv_rdy stays 1 with the new byte.
  - Status read (stb=1, we=0, addr=0) clears ovr and ferr at that edge. A flag set by an event in the same cycle wins over the clear.
  - Writes (we=1) have no effect on any state.
- Width rules:
  - cnt is wide enough for BAUD_DIV−1 (clog2).
  - The bit index is 3 bits plus a terminal condition. It must not wrap into a 9th data sample.

## Timing
- Synchronizer latency: 2 cycles from the rxd pin to rxd_s. Edge detect adds 1 more.
- The START sample lands BAUD_DIV/2 cycles after entering START, i.e. mid start bit.
- Data bit k is sampled (k+1)·BAUD_DIV cycles after the START sample.
- The STOP sample is 9·BAUD_DIV cycles after the START sample. rcv_rdy goes high 1 cycle after that.
- At the earliest, the FSM is in IDLE the cycle after the STOP sample. This allows back-to-back frames with a one-bit stop.
- data_out is valid in the same cycle as stb/addr, with zero wait states. Flag clears take effect from the next cycle.

## Test plan
- Reset and idle: hold rst=0 for 3 cycles with rxd=1, then release. Read status → 8'h00; read data → 8'h00. Idle for 100 cycles → no change.
- Single byte (BAUD_DIV=16): drive 8'hA5 as 8N1. Status → 8'h01; data → 8'hA5; status again → 8'h00.
- Glitch rejection: pulse rxd low for 4 cycles (less than BAUD_DIV/2=8). Status stays 8'h00, the FSM returns to IDLE, and a following 8'h3C frame is received correctly.
- Framing error: send 8'h55 with stop bit 0. Status → 8'h02, rcv_rdy=0. Reading status clears it to 8'h00. The next valid frame 8'h0F is received.
- Overrun: send 8'h11 then 8'h22 with no read. Status → 8'h03; data → 8'h11; status → 8'h00 afterwards.
- Simultaneous delivery and read: with 8'h11 pending, issue a data read in the exact cycle the 8'h22 delivery occurs. The read returns 8'h11; afterwards status → 8'h01 and data → 8'h22. ovr is never set.

Source files
------------

// File: rtl/serrcv.sv
// serrcv: 8N1 serial line receiver with a one-entry receive buffer,
// presented to the host as a status/data register window.
module serrcv #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stb,
    input  logic       we,
    input  logic       addr,
    output logic [7:0] data_out,
    input  logic       rxd
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          dlv, dlv_n;
    logic          ferr_ev, ferr_ev_n;

    logic          rxd_m, rxd_s, rxd_q;
    logic [7:0]    rcv_buf;
    logic          rcv_rdy, ovr, ferr;

    logic          rd_data, rd_stat;

    assign rd_data = stb & ~we & addr;
    assign rd_stat = stb & ~we & ~addr;

    // Next-state logic for the bit-timing FSM
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shreg_n   = shreg;
        dlv_n     = 1'b0;
        ferr_ev_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxd_s && rxd_q) begin
                    cnt_n   = HALF_LOAD;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    if (!rxd_s) begin
                        cnt_n   = FULL_LOAD;
                        idx_n   = 3'd0;
                        state_n = S_DATA;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    shreg_n = {rxd_s, shreg[7:1]};
                    cnt_n   = FULL_LOAD;
                    // Terminal index moves to STOP instead of wrapping
                    if (idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    dlv_n     = rxd_s;
                    ferr_ev_n = ~rxd_s;
                    state_n   = S_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Synchronizer, FSM registers and delivery pipeline
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_m   <= 1'b1;
            rxd_s   <= 1'b1;
            rxd_q   <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= 3'd0;
            shreg   <= 8'h00;
            dlv     <= 1'b0;
            ferr_ev <= 1'b0;
        end else begin
            rxd_m   <= rxd;
            rxd_s   <= rxd_m;
            rxd_q   <= rxd_s;
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            dlv     <= dlv_n;
            ferr_ev <= ferr_ev_n;
        end
    end

    // Host-visible buffer and flags; events win over read clears
    always_ff @(posedge clk) begin
        if (!rst) begin
            rcv_buf <= 8'h00;
            rcv_rdy <= 1'b0;
            ovr     <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (dlv && (!rcv_rdy || rd_data)) begin
                rcv_buf <= shreg;
                rcv_rdy <= 1'b1;
            end else if (rd_data) begin
                rcv_rdy <= 1'b0;
            end

            if (dlv && rcv_rdy && !rd_data) begin
                ovr <= 1'b1;
            end else if (rd_stat) begin
                ovr <= 1'b0;
            end

            if (ferr_ev) begin
                ferr <= 1'b1;
            end else if (rd_stat) begin
                ferr <= 1'b0;
            end
        end
    end

    always_comb begin
        data_out = addr ? rcv_buf : {6'b0, ferr | ovr, rcv_rdy};
    end

endmodule
